// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch FSM driving PC strobes, a single
// outstanding memory read and a valid/ack instruction port.
module fetch_sequencer #(
  parameter int DATA_LEN = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [DATA_LEN-1:0] pc_in,
  output logic                pc_inc,
  output logic                pc_we,
  output logic [DATA_LEN-1:0] c_bus_out,
  input  logic                jump_req,
  input  logic [DATA_LEN-1:0] jump_addr,
  output logic                jump_done,
  output logic                mem_rd,
  output logic [DATA_LEN-1:0] mem_addr,
  input  logic                mem_ready,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic [DATA_LEN-1:0] instr_out,
  output logic                instr_valid,
  input  logic                instr_ack,
  output logic                busy,
  output logic                err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_INC     = 3'd2;
  localparam logic [2:0] S_DELIVER = 3'd3;
  localparam logic [2:0] S_LOAD    = 3'd4;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]          state;
  logic [2:0]          state_nx;
  logic                run;
  logic [7:0]          wait_cnt;
  logic [DATA_LEN-1:0] jaddr;
  logic                go;
  logic                timeout_hit;
  logic                jump_take;

  assign go = start && !stop;

  // abort on the last permitted ready-less cycle of ISSUE
  assign timeout_hit = (state == S_ISSUE) && !mem_ready
                    && (wait_cnt == WAIT_LAST);

  assign jump_take = jump_req
    && ((state == S_IDLE)
     || ((state == S_DELIVER) && instr_ack));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (jump_req)
          state_nx = S_LOAD;
        else if (go)
          state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_ready)
          state_nx = S_INC;
        else if (timeout_hit)
          state_nx = S_IDLE;
      end
      S_INC:
        state_nx = S_DELIVER;
      S_DELIVER: begin
        if (instr_ack) begin
          if (jump_req)
            state_nx = S_LOAD;
          else if (run)
            state_nx = S_ISSUE;
          else
            state_nx = S_IDLE;
        end
      end
      S_LOAD:
        state_nx = run ? S_ISSUE : S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      run       <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= 8'd0;
      instr_out <= '0;
      jaddr     <= '0;
    end else begin
      state <= state_nx;

      if (stop || timeout_hit)
        run <= 1'b0;
      else if (start)
        run <= 1'b1;

      if ((state == S_IDLE) && go)
        err <= 1'b0;
      else if (timeout_hit)
        err <= 1'b1;

      if (state != S_ISSUE)
        wait_cnt <= 8'd0;
      else if (!mem_ready)
        wait_cnt <= wait_cnt + 8'd1;

      if ((state == S_ISSUE) && mem_ready)
        instr_out <= mem_rdata;

      if (jump_take)
        jaddr <= jump_addr;
    end
  end

  assign mem_rd      = (state == S_ISSUE);
  assign mem_addr    = mem_rd ? pc_in : '0;
  assign pc_inc      = (state == S_INC);
  assign instr_valid = (state == S_DELIVER);
  assign pc_we       = (state == S_LOAD);
  assign jump_done   = pc_we;
  assign c_bus_out   = pc_we ? jaddr : '0;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed flow with a scoreboard of
// fetched words and a PC register model around the DUT.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] pc = 16'h0010;
  logic        pc_inc;
  logic        pc_we;
  logic [15:0] c_bus_out;
  logic        jump_req;
  logic [15:0] jump_addr;
  logic        jump_done;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ack;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int both_cnt = 0;
  int n_rd;
  int n_inc;
  logic [15:0] sb[$];
  logic [15:0] exp_w;

  fetch_sequencer #(.DATA_LEN(16), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pc_in       (pc),
    .pc_inc      (pc_inc),
    .pc_we       (pc_we),
    .c_bus_out   (c_bus_out),
    .jump_req    (jump_req),
    .jump_addr   (jump_addr),
    .jump_done   (jump_done),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_inc)
      pc <= pc + 16'd1;
    else if (pc_we)
      pc <= c_bus_out;
  end

  always @(negedge clk)
    if (pc_inc && pc_we)
      both_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  // compare the delivered word with the oldest scoreboard entry
  task automatic take(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'd0, 32'd1);
      exp_w = 16'hxxxx;
    end else begin
      exp_w = sb.pop_front();
      chk({tag, "_word"}, 32'(instr_out), 32'(exp_w));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    jump_req = 1'b0; jump_addr = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    instr_ack = 1'b0;
    cyc; cyc;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_inc", 32'(pc_inc), 32'd0);
    chk("rst_we", 32'(pc_we), 32'd0);
    chk("rst_cbus", 32'(c_bus_out), 32'd0);
    chk("rst_jd", 32'(jump_done), 32'd0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // basic fetch with same-cycle ready
    reset = 1'b0; start = 1'b1;
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    sb.push_back(16'hA5A5);
    cyc;
    chk("f0_rd", 32'(mem_rd), 32'd1);
    chk("f0_addr", 32'(mem_addr), 32'h0010);
    chk("f0_busy", 32'(busy), 32'd1);
    start = 1'b0;
    cyc;
    chk("f0_inc", 32'(pc_inc), 32'd1);
    chk("f0_rd_lo", 32'(mem_rd), 32'd0);
    chk("f0_we_lo", 32'(pc_we), 32'd0);
    mem_ready = 1'b0;
    cyc;
    chk("f0_inc_lo", 32'(pc_inc), 32'd0);
    take("f0");

    // consumer withholds ack
    for (int i = 0; i < 5; i++) begin
      cyc;
      chk("hold_vld", 32'(instr_valid), 32'd1);
      chk("hold_word", 32'(instr_out), 32'(exp_w));
      chk("hold_rd", 32'(mem_rd), 32'd0);
    end

    // ack together with a jump
    instr_ack = 1'b1; jump_req = 1'b1;
    jump_addr = 16'h0200;
    cyc;
    chk("j_we", 32'(pc_we), 32'd1);
    chk("j_cbus", 32'(c_bus_out), 32'h0200);
    chk("j_done", 32'(jump_done), 32'd1);
    chk("j_inc", 32'(pc_inc), 32'd0);
    instr_ack = 1'b0; jump_req = 1'b0;
    jump_addr = 16'hFFFF;
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    sb.push_back(16'h1234);
    cyc;
    chk("j_rd", 32'(mem_rd), 32'd1);
    chk("j_addr", 32'(mem_addr), 32'h0200);
    chk("j_cbus0", 32'(c_bus_out), 32'd0);
    cyc;
    chk("f1_inc", 32'(pc_inc), 32'd1);
    mem_ready = 1'b0;
    cyc;
    take("f1");
    instr_ack = 1'b1;
    cyc;
    instr_ack = 1'b0;

    // memory never answers
    n_rd = 0; n_inc = 0;
    for (int i = 0; i < 15; i++) begin
      n_rd += int'(mem_rd);
      n_inc += int'(pc_inc);
      cyc;
    end
    chk("to_cycles", 32'(n_rd), 32'd15);
    chk("to_noinc", 32'(n_inc), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_rd", 32'(mem_rd), 32'd0);
    chk("to_pc", 32'(pc), 32'h0201);
    chk("to_instr", 32'(instr_out), 32'h1234);

    // start and stop together: stay idle
    start = 1'b1; stop = 1'b1;
    cyc;
    chk("ss_busy", 32'(busy), 32'd0);
    chk("ss_err", 32'(err), 32'd1);
    start = 1'b0; stop = 1'b0;
    cyc;
    chk("ss_busy2", 32'(busy), 32'd0);

    // restart clears err; stop mid-read still delivers
    start = 1'b1;
    cyc;
    chk("rs_err", 32'(err), 32'd0);
    chk("rs_rd", 32'(mem_rd), 32'd1);
    chk("rs_addr", 32'(mem_addr), 32'h0201);
    start = 1'b0; stop = 1'b1;
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    sb.push_back(16'hBEEF);
    cyc;
    chk("st_inc", 32'(pc_inc), 32'd1);
    stop = 1'b0; mem_ready = 1'b0;
    cyc;
    take("st");
    instr_ack = 1'b1;
    cyc;
    chk("st_idle", 32'(busy), 32'd0);
    chk("st_rd", 32'(mem_rd), 32'd0);
    instr_ack = 1'b0;

    // jump from idle without run returns to idle
    jump_req = 1'b1; jump_addr = 16'h0300;
    cyc;
    chk("ij_we", 32'(pc_we), 32'd1);
    chk("ij_cbus", 32'(c_bus_out), 32'h0300);
    jump_req = 1'b0;
    cyc;
    chk("ij_idle", 32'(busy), 32'd0);
    chk("ij_pc", 32'(pc), 32'h0300);

    // reset during a pending read
    start = 1'b1;
    cyc;
    chk("rr_rd", 32'(mem_rd), 32'd1);
    start = 1'b0; reset = 1'b1;
    cyc;
    chk("rr_rd0", 32'(mem_rd), 32'd0);
    chk("rr_addr0", 32'(mem_addr), 32'd0);
    chk("rr_busy0", 32'(busy), 32'd0);
    chk("rr_instr0", 32'(instr_out), 32'd0);
    reset = 1'b0;
    cyc;
    chk("rr_stay", 32'(busy), 32'd0);

    // jump outranks start; reset during load
    jump_req = 1'b1; jump_addr = 16'h0400;
    start = 1'b1;
    cyc;
    chk("rl_we", 32'(pc_we), 32'd1);
    chk("rl_rd", 32'(mem_rd), 32'd0);
    jump_req = 1'b0; start = 1'b0; reset = 1'b1;
    cyc;
    chk("rl_we0", 32'(pc_we), 32'd0);
    chk("rl_jd0", 32'(jump_done), 32'd0);
    chk("rl_cbus0", 32'(c_bus_out), 32'd0);
    chk("rl_busy0", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc;
    chk("rl_stay", 32'(busy), 32'd0);

    chk("excl", 32'(both_cnt), 32'd0);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DATA_LEN, default 16, width of PC, address, instruction and jump-address paths.
REQ-002 Parameter TIMEOUT, default 15, maximum ISSUE-state cycles without mem_ready before abort; legal range 1..255.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  sets run flag; begins fetching from IDLE.
REQ-006 stop  input  1  clears run flag; sequencer returns to IDLE at next instruction boundary.
REQ-007 pc_in  input  DATA_LEN  current value of the incrementing PC register.
REQ-008 pc_inc  output  1  one-cycle increment strobe to the PC register.
REQ-009 pc_we  output  1  one-cycle write-enable strobe to the PC register.
REQ-010 c_bus_out  output  DATA_LEN  value for the PC register to load when pc_we=1; 0 otherwise.
REQ-011 jump_req  input  1  jump request; requester holds it high until jump_done.
REQ-012 jump_addr  input  DATA_LEN  jump target, sampled when jump_req is accepted.
REQ-013 jump_done  output  1  one-cycle pulse, coincident with pc_we.
REQ-014 mem_rd  output  1  read request; held high until mem_ready.
REQ-015 mem_addr  output  DATA_LEN  equals pc_in while mem_rd=1, else 0.
REQ-016 mem_ready  input  1  read data valid this cycle.
REQ-017 mem_rdata  input  DATA_LEN  instruction word.
REQ-018 instr_out  output  DATA_LEN  last captured instruction, registered.
REQ-019 instr_valid  output  1  instr_out available to the consumer.
REQ-020 instr_ack  input  1  consumer accepts instr_out.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 err  output  1  sticky memory-timeout flag.

Function
REQ-023 The FSM SHALL have states IDLE, ISSUE, INC, DELIVER, LOAD; all control outputs are Moore-decoded from state.
REQ-024 IDLE: jump_req=1 -> LOAD (priority); else start=1 and stop=0 -> ISSUE; else stay.
REQ-025 The run flag SHALL be set by start and cleared by stop; stop wins when both are asserted in the same cycle.
REQ-026 ISSUE: mem_rd=1, mem_addr=pc_in; on mem_ready=1, instr_out<=mem_rdata and state -> INC.
REQ-027 INC: pc_inc=1 for exactly one cycle -> DELIVER.
REQ-028 DELIVER: instr_valid=1; on instr_ack: jump_req -> LOAD, else run -> ISSUE, else IDLE; without instr_ack the state holds and instr_out is stable.
REQ-029 LOAD: pc_we=1, jump_done=1, c_bus_out=jump_addr latched on acceptance -> ISSUE if run, else IDLE.
REQ-030 pc_inc and pc_we SHALL never be asserted in the same cycle.
REQ-031 jump_req SHALL be ignored in ISSUE, INC and LOAD.
REQ-032 Minimum per-instruction latency: ISSUE with same-cycle mem_ready, INC, DELIVER with same-cycle ack = 3 cycles.
REQ-033 ISSUE SHALL increment a wait counter on each cycle with mem_ready=0; the counter clears on entry to ISSUE.
REQ-034 When the counter reaches TIMEOUT while in ISSUE, the block SHALL set err, clear run and go to IDLE, with no pc_inc and instr_out unchanged.
REQ-035 err SHALL clear when start is accepted in IDLE.
REQ-036 stop during ISSUE SHALL NOT abort the outstanding read; the current instruction completes through DELIVER first.

Reset
REQ-037 On reset=1 at a clock edge: state=IDLE; run=0, err=0, counter=0, instr_out=0; all outputs 0 in the following cycle.
REQ-038 Reset SHALL override every other input, including reset mid-ISSUE (mem_rd low next cycle) and mid-LOAD.

Verification
REQ-039 Reset, start=1, pc_in=0x0010, mem_ready same cycle with rdata=0xA5A5 -> mem_addr=0x0010, pc_inc one pulse, instr_valid with instr_out=0xA5A5.
REQ-040 DELIVER, instr_ack+jump_req with jump_addr=0x0200 -> next cycle pc_we=1, c_bus_out=0x0200, jump_done=1, pc_inc=0; then ISSUE.
REQ-041 mem_ready held low for TIMEOUT=15 cycles -> err=1, busy=0, mem_rd=0, no pc_inc; start then clears err.
REQ-042 instr_ack withheld for 5 cycles -> instr_valid and instr_out stable; no new mem_rd.
REQ-043 start+stop in the same cycle in IDLE -> remains IDLE; stop asserted during ISSUE -> current fetch delivered, then IDLE.
REQ-044 reset asserted while mem_rd=1 -> next cycle all outputs 0, state IDLE.
